serial_addsub_ctrl: RTL and testbench



---
 rtl/serial_addsub_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder/subtractor cell stepped LSB-first.
// Optional macro SERIAL_ADDSUB_OVERFLOW_EN adds a signed overflow output.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               cy_q, cy_d;
  logic               op_q, op_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic               sum_bit;
  logic               c_next;

  // Returns {carry/borrow out, sum/difference bit}.
  function automatic logic [1:0] addsub_bit(input logic x, input logic y,
                                            input logic c, input logic sub);
    logic xe;
    xe = sub ? ~x : x;
    return {(xe & y) | (y & c) | (c & xe), x ^ y ^ c};
  endfunction

  always_comb begin
    {c_next, sum_bit} = addsub_bit(a_sh_q[0], b_sh_q[0], cy_q, op_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          cnt_d   = '0;
          cy_d    = 1'b0;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        acc_d  = {sum_bit, acc_q[WIDTH-1:1]};
        cy_d   = c_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: publish the fully shifted accumulator and the final carry.
          state_d  = DONE;
          cnt_d    = '0;
          result_d = {sum_bit, acc_q[WIDTH-1:1]};
          carry_d  = c_next;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
          // cy_q here is the carry/borrow into the MSB.
          ovf_d    = cy_q ^ c_next;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      op_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cy_q     <= cy_d;
      op_q     <= op_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: vector table, protocol/reset sequences,
// and random operations against an arithmetic reference model.
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, carry_out;
  logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_res = '0;
  logic         prev_cy  = 1'b0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out)
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_c;
    logic         exp_v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux, uy, sx, sy, r, sr;
    logic [W-1:0] res;
    logic cy, ov;
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    if (!o) begin
      r = ux + uy; cy = (r >= (64'sd1 <<< W)); sr = sx + sy;
    end else begin
      r = ux - uy; cy = (ux < uy); sr = sx - sy;
    end
    res = r[W-1:0];
    ov = (sr > (64'sd1 <<< (W-1)) - 1) || (sr < -(64'sd1 <<< (W-1)));
    return {ov, cy, res};
  endfunction

  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    @(negedge clk);
    chk("ready_before", ready, 1'b1);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      chk("run_state", {busy, done, ready, carry_out, result}, {4'b100, prev_cy, prev_res});
    end
    @(negedge clk);
    chk("done_flags", {busy, done, ready}, 3'b010);
    chk("result", result, er);
    chk("carry_out", carry_out, ec);
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    chk("overflow", overflow, ev);
`else
    if (ev === 1'bx) chk("ov_unused", ev, 1'b0);
`endif
    @(negedge clk);
    chk("back_idle", {busy, done, ready, carry_out, result}, {4'b001, ec, er});
    prev_res = er; prev_cy = ec;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h37, 8'h37, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};

    // Reset with start held: reset must win.
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset_state", {ready, busy, done, carry_out, result}, {4'b1000, 8'h00});
    @(posedge clk); @(negedge clk);
    chk("reset_beats_start", {ready, busy, done}, 3'b100);
    start = 1'b0; rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_c, vecs[i].exp_v);

    // start pulses and operand changes during RUN/DONE must be ignored.
    begin
      int dones = 0;
      @(negedge clk);
      op = 1'b0; a = 8'h5A; b = 8'h3C; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= W + 1; k++) begin
        @(negedge clk);
        if (done) dones++;
        if (done) chk("proto_result", {carry_out, result}, {1'b0, 8'h96});
        start = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) dones++;
      end
      chk("proto_one_done", dones, 1);
      chk("proto_hold", result, 8'h96);
      prev_res = 8'h96; prev_cy = 1'b0;
    end

    // start held high: accepts every W+2 cycles.
    begin
      int rises[$];
      logic pb = 1'b0;
      @(negedge clk);
      op = 1'b0; a = 8'h5A; b = 8'h3C; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
        if (i > 0) @(negedge clk);
        if (busy && !pb) rises.push_back(i);
        pb = busy;
      end
      start = 1'b0;
      chk("hold_count", rises.size(), 3);
      if (rises.size() == 3) begin
        chk("hold_t0", rises[0], 1);
        chk("hold_t1", rises[1], 11);
        chk("hold_t2", rises[2], 21);
      end
      repeat (3) @(negedge clk);
      chk("hold_idle", {ready, result}, {1'b1, 8'h96});
    end

    // Abort mid-RUN with reset.
    begin
      int dones = 0;
      @(negedge clk);
      op = 1'b0; a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("abort_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_state", {ready, busy, done, carry_out, result}, {4'b1000, 8'h00});
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) dones++;
      end
      chk("abort_no_done", dones, 0);
      prev_res = '0; prev_cy = 1'b0;
    end

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic o;
      logic [W-1:0] x, y;
      logic [W+1:0] m;
      o = 1'($urandom_range(0, 1));
      x = W'($urandom); y = W'($urandom);
      m = model(o, x, y);
      do_op(o, x, y, m[W-1:0], m[W], m[W+1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
